alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream command stage for the 8-bit ALU (add/sub/mul). Accepts one operation per
//  valid/ready handshake and registers operands/select/carry onto the ALU inputs.
//  Waits a fixed settle time, then captures the ALU's 16-bit result and flag into a
//  held output register with its own valid/ready handshake.
//  Adds a CHAIN op that feeds the previous result's low byte back in as operand A.
// PARAMETERS
//  DATA_W        8   operand width; the ALU result width is 2*DATA_W
//  SETTLE_CYCLES 1   cycles the ALU inputs are held before capture; legal range 1..15
// PORTS
//  clk        in   1         single clock, all state on rising edge
//  rst        in   1         synchronous, active-high reset
//  cmd_valid  in   1         command present
//  cmd_ready  out  1         sequencer can accept a command
//  cmd_op     in   2         00 add, 01 sub, 10 mul, 11 chain-add
//  cmd_a      in   DATA_W    operand A (ignored for chain-add)
//  cmd_b      in   DATA_W    operand B
//  cmd_c      in   1         carry/borrow in (add, sub, chain-add)
//  alu_A      out  DATA_W    registered operand A to ALU
//  alu_B      out  DATA_W    registered operand B to ALU
//  alu_c      out  1         registered carry to ALU
//  alu_sel    out  2         registered ALU select (00/01/10 only)
//  alu_out    in   2*DATA_W  ALU result
//  alu_flag   in   1         ALU carry/borrow/overflow flag
//  res_valid  out  1         captured result available
//  res_ready  in   1         consumer takes result
//  res_data   out  2*DATA_W  captured result
//  res_flag   out  1         captured flag
//  op_count   out  8         completed ops (result handshakes), wraps 255->0
// BEHAVIOUR
//  - Reset: state=IDLE; every output =0 except cmd_ready=1; internal last_res=0;
//    wait counter=0. A reset mid-operation discards any in-flight or held result.
//  - FSM states IDLE, WAIT, HOLD:
//    IDLE: cmd_ready=1. On cmd_valid: load alu_* regs, counter=SETTLE_CYCLES-1, ->WAIT.
//    WAIT: cmd_ready=0, alu_* regs held stable. If counter==0: res_data<=alu_out,
//          res_flag<=alu_flag, last_res<=alu_out, res_valid<=1, ->HOLD; else counter-1.
//    HOLD: res_valid=1, res_data/res_flag stable. On res_ready: res_valid<=0,
//          op_count+1, ->IDLE. A command is not accepted in the same cycle.
//  - Op decode at accept:
//    op 00/01/10 -> alu_sel=op, alu_A=cmd_a.
//    op 11 -> alu_sel=00, alu_A=last_res[DATA_W-1:0].
//    All ops: alu_B=cmd_b, alu_c=cmd_c.
//  - Latency: command accepted at edge T -> res_valid high from cycle T+SETTLE_CYCLES+1.
//    Minimum issue interval = SETTLE_CYCLES+2 cycles.
//  - Zero-extension: add/sub results are zero-extended to 2*DATA_W by the ALU; the
//    sequencer captures all 2*DATA_W bits unchanged. last_res updates only on capture.
//  - cmd_* are sampled only on the accepting edge. Later changes have no effect.
//  - alu_* registers keep their last values in IDLE/HOLD; they are cleared only by rst.
// TESTING
//  1 Reset: hold rst 2 cycles -> cmd_ready=1, res_valid=0, op_count=0, alu_*=0.
//  2 Add: op=00 a=0x7F b=0x01 c=0, res_ready=1 (SETTLE=1) -> res_valid at T+2,
//    res_data=0x0080, flag=0.
//  3 Add carry: op=00 a=0xFF b=0x01 c=0 -> res_data=0x0000, res_flag=1.
//  4 Mul: op=10 a=0x10 b=0x10 -> res_data=0x0100.
//  5 Chain: after test 2, op=11 a=0xAA(ignored) b=0x05 c=1 -> alu_A=0x80,
//    res_data=0x0086.
//  6 Backpressure and reset: res_ready=0 for 5 cycles -> result held, cmd_ready=0,
//    cmd_valid ignored; assert rst in HOLD -> next cycle res_valid=0, cmd_ready=1,
//    op_count unchanged (0 if first op).
//  7 Wrap: 256 completed ops -> op_count=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command stage in front of the 8-bit ALU: registers one op per handshake, waits a
// fixed settle time, captures the ALU result into a held valid/ready output register.
module alu_cmd_sequencer #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_W-1:0]     cmd_a,
    input  logic [DATA_W-1:0]     cmd_b,
    input  logic                  cmd_c,
    output logic [DATA_W-1:0]     alu_A,
    output logic [DATA_W-1:0]     alu_B,
    output logic                  alu_c,
    output logic [1:0]            alu_sel,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_flag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DATA_W-1:0]   res_data,
    output logic                  res_flag,
    output logic [7:0]            op_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t              state, state_nxt;
    logic [3:0]          wait_cnt;
    logic [2*DATA_W-1:0] last_res;
    logic                accept, capture, release_res;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // alu_* only change on accept so the ALU sees stable inputs across the settle window
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_A     <= '0;
            alu_B     <= '0;
            alu_c     <= 1'b0;
            alu_sel   <= 2'b00;
            wait_cnt  <= 4'd0;
            last_res  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flag  <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            if (accept) begin
                alu_A    <= (cmd_op == 2'b11) ? last_res[DATA_W-1:0] : cmd_a;
                alu_B    <= cmd_b;
                alu_c    <= cmd_c;
                alu_sel  <= (cmd_op == 2'b11) ? 2'b00 : cmd_op;
                wait_cnt <= SETTLE_INIT;
            end
            if (state == S_WAIT && !capture)
                wait_cnt <= wait_cnt - 4'd1;
            if (capture) begin
                res_data  <= alu_out;
                res_flag  <= alu_flag;
                last_res  <= alu_out;
                res_valid <= 1'b1;
            end
            if (release_res) begin
                res_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, timestamp-based reference model,
// per-cycle compare plus directed literal checks.
module tb_alu_cmd_sequencer;

    localparam int DW     = 8;
    localparam int SETTLE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [DW-1:0] cmd_a = '0, cmd_b = '0;
    logic          cmd_c = 1'b0;
    logic [DW-1:0] alu_A, alu_B;
    logic          alu_c;
    logic [1:0]    alu_sel;
    logic [15:0]   alu_out;
    logic          alu_flag;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [15:0]   res_data;
    logic          res_flag;
    logic [7:0]    op_count;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    alu_cmd_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
        .alu_A(alu_A), .alu_B(alu_B), .alu_c(alu_c), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flag(res_flag), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // {flag, result}: add/sub zero-extended with carry/borrow, mul flags a nonzero high byte
    function automatic logic [16:0] alu_f(input logic [1:0] sel, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
        logic [8:0]  s;
        logic [15:0] p;
        case (sel)
            2'b00: begin s = {1'b0, a} + {1'b0, b} + {8'd0, c}; return {s[8], 8'h00, s[7:0]}; end
            2'b01: begin s = {1'b0, a} - {1'b0, b} - {8'd0, c}; return {s[8], 8'h00, s[7:0]}; end
            2'b10: begin p = 16'(a) * 16'(b); return {|p[15:8], p}; end
            default: return 17'd0;
        endcase
    endfunction

    assign {alu_flag, alu_out} = alu_f(alu_sel, alu_A, alu_B, alu_c);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: busy until a capture timestamp, then holding until res_ready.
    bit          m_busy, m_hold;
    int          cyc, m_cap_at;
    logic [7:0]  m_A, m_B, m_cnt;
    logic        m_c, m_flag;
    logic [1:0]  m_sel;
    logic [15:0] m_res, m_last;

    always @(posedge clk) begin
        logic [16:0] r;
        if (rst) begin
            m_busy = 0; m_hold = 0; m_cnt = 0; m_last = 0; m_res = 0; m_flag = 0;
            m_A = 0; m_B = 0; m_c = 0; m_sel = 0;
        end else if (!m_busy && !m_hold) begin
            if (cmd_valid) begin
                m_A      = (cmd_op == 2'b11) ? m_last[7:0] : cmd_a;
                m_B      = cmd_b;
                m_c      = cmd_c;
                m_sel    = (cmd_op == 2'b11) ? 2'b00 : cmd_op;
                m_cap_at = cyc + SETTLE;
                m_busy   = 1;
            end
        end else if (m_busy) begin
            if (cyc == m_cap_at) begin
                r      = alu_f(m_sel, m_A, m_B, m_c);
                m_res  = r[15:0];
                m_flag = r[16];
                m_last = r[15:0];
                m_busy = 0;
                m_hold = 1;
            end
        end else if (res_ready) begin
            m_hold = 0;
            m_cnt  = m_cnt + 8'd1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            check("cmd_ready", 32'(cmd_ready), 32'(!(m_busy || m_hold)));
            check("res_valid", 32'(res_valid), 32'(m_hold));
            check("res_data",  32'(res_data),  32'(m_res));
            check("res_flag",  32'(res_flag),  32'(m_flag));
            check("op_count",  32'(op_count),  32'(m_cnt));
            check("alu_regs",  {13'd0, alu_sel, alu_c, alu_A, alu_B}, {13'd0, m_sel, m_c, m_A, m_B});
        end
    end

    // Issue one command, return captured result and cycles from accept to res_valid.
    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, output logic [15:0] d, output logic f, output int lat);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_c = c;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_c = 1'($urandom);
        lat = 1;
        while (!res_valid && lat < 50) begin @(negedge clk); lat++; end
        check("res_valid_timeout", 32'(res_valid), 32'd1);
        d = res_data;
        f = res_flag;
    endtask

    initial begin
        logic [15:0] d;
        logic        f;
        int          lat;

        repeat (2) @(negedge clk);
        started = 1'b1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        check("rst_alu_A",     32'(alu_A),     32'd0);
        rst = 1'b0;

        do_op(2'b00, 8'h7F, 8'h01, 1'b0, d, f, lat);
        check("add_data", 32'(d), 32'h0080);
        check("add_flag", 32'(f), 32'd0);
        check("add_latency", 32'(lat), 32'(SETTLE + 1));
        check("add_alu_A", 32'(alu_A), 32'h7F);
        @(negedge clk);

        do_op(2'b11, 8'hAA, 8'h05, 1'b1, d, f, lat);
        check("chain_alu_A", 32'(alu_A), 32'h80);
        check("chain_alu_sel", 32'(alu_sel), 32'd0);
        check("chain_data", 32'(d), 32'h0086);
        @(negedge clk);

        do_op(2'b00, 8'hFF, 8'h01, 1'b0, d, f, lat);
        check("carry_data", 32'(d), 32'h0000);
        check("carry_flag", 32'(f), 32'd1);
        @(negedge clk);

        do_op(2'b10, 8'h10, 8'h10, 1'b0, d, f, lat);
        check("mul_data", 32'(d), 32'h0100);
        @(negedge clk);

        do_op(2'b01, 8'h05, 8'h07, 1'b0, d, f, lat);
        check("sub_data", 32'(d), 32'h00FE);
        check("sub_flag", 32'(f), 32'd1);
        @(negedge clk);

        // backpressure then reset while holding
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        res_ready = 1'b0;
        do_op(2'b00, 8'h12, 8'h34, 1'b0, d, f, lat);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 8'h99; cmd_b = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_res_data",  32'(res_data),  32'h0046);
            check("bp_alu_A",     32'(alu_A),     32'h12);
        end
        rst = 1'b1;
        @(negedge clk);
        check("hold_rst_res_valid", 32'(res_valid), 32'd0);
        check("hold_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("hold_rst_op_count",  32'(op_count),  32'd0);
        rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;

        for (int i = 0; i < 600; i++) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_c     = 1'($urandom);
            res_ready = ($urandom % 4) != 0;
            @(negedge clk);
        end
        cmd_valid = 1'b0; res_ready = 1'b1;
        repeat (4) @(negedge clk);

        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            do_op(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), d, f, lat);
            @(negedge clk);
            if (i == 255) check("count_255", 32'(op_count), 32'd255);
        end
        check("count_wrap", 32'(op_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
